// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution unit: operand-select and carry-select
// codes, named logic truth tables, flag bit positions and the captured control word.
package alu_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        LHS_A    = 2'b00,
        LHS_ZERO = 2'b01,
        LHS_ONES = 2'b10,
        LHS_RSVD = 2'b11
    } lhs_sel_e;

    typedef enum logic [1:0] {
        CS_ZERO = 2'b00,
        CS_ONE  = 2'b01,
        CS_FLAG = 2'b10,
        CS_RSVD = 2'b11
    } cs_sel_e;

    // Truth tables are indexed by {lhs_bit, rhs_bit}
    localparam logic [3:0] TT_B   = 4'b1010;
    localparam logic [3:0] TT_NB  = 4'b0101;
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    typedef struct packed {
        cs_sel_e    cs;
        lhs_sel_e   lhs;
        logic [3:0] rhs;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_logic_unit.sv
// Bitwise logic stage: each result bit is the truth-table entry selected by
// the corresponding {A,B} bit pair.
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   tt_i,
    output logic [W-1:0] y_o
);

    // Per-bit 4:1 truth-table mux
    always_comb begin
        y_o = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            y_o[i] = tt_i[{a_i[i], b_i[i]}];
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage ALU execution unit: issue register, then adder result and
// C/Z/N/V flag register driving the writeback bus.
module alu_exec_unit #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             AluClock,
    input  logic             AluActive,
    input  logic             AC0_RHS0,
    input  logic             AC1_RHS1,
    input  logic             AC2_RHS2,
    input  logic             AC3_RHS3,
    input  logic             AC4_LHS0,
    input  logic             AC5_LHS1,
    input  logic             AC6_CS0,
    input  logic             AC7_CS1,
    input  logic [WIDTH-1:0] LhsIn,
    input  logic [WIDTH-1:0] RhsIn,
    output logic [WIDTH-1:0] ResultOut,
    output logic             ResultValid,
    output logic             ResultBusOE,
    output logic             FlagC,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagV
);
    import alu_pkg::*;

    logic             issue_s;
    logic             s1_valid_q;
    logic [WIDTH-1:0] lhs_q;
    logic [WIDTH-1:0] rhs_q;
    alu_ctrl_t        ctrl_q;

    logic [WIDTH-1:0] logic_s;
    logic [WIDTH-1:0] lhs_val_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;

    logic [WIDTH-1:0] result_d, result_q;
    logic [3:0]       flags_d, flags_q;
    logic             valid_d, valid_q;

    assign issue_s = AluActive & AluClock;

    // Issue stage: operands and control captured only on an issue strobe
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            s1_valid_q <= 1'b0;
            lhs_q      <= {WIDTH{1'b0}};
            rhs_q      <= {WIDTH{1'b0}};
            ctrl_q     <= alu_ctrl_t'(8'h00);
        end else begin
            s1_valid_q <= issue_s;
            if (issue_s) begin
                lhs_q  <= LhsIn;
                rhs_q  <= RhsIn;
                ctrl_q <= alu_ctrl_t'({AC7_CS1, AC6_CS0, AC5_LHS1, AC4_LHS0,
                                       AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0});
            end
        end
    end

    alu_logic_unit #(.W(WIDTH)) u_logic (
        .a_i  (lhs_q),
        .b_i  (rhs_q),
        .tt_i (ctrl_q.rhs),
        .y_o  (logic_s)
    );

    // Adder LHS select; the reserved code behaves like plain A
    always_comb begin
        case (ctrl_q.lhs)
            LHS_A:    lhs_val_s = lhs_q;
            LHS_ZERO: lhs_val_s = {WIDTH{1'b0}};
            LHS_ONES: lhs_val_s = {WIDTH{1'b1}};
            default:  lhs_val_s = lhs_q;
        endcase
    end

    // Carry-in select; flags_q already holds the carry of the op one stage ahead
    always_comb begin
        case (ctrl_q.cs)
            CS_ZERO: cin_s = 1'b0;
            CS_ONE:  cin_s = 1'b1;
            CS_FLAG: cin_s = flags_q[FLAG_C];
            default: cin_s = 1'b0;
        endcase
    end

    assign sum_s = {1'b0, lhs_val_s} + {1'b0, logic_s} + {{WIDTH{1'b0}}, cin_s};

    // Result and flag next-state: only a completed op changes them
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = s1_valid_q;
        if (s1_valid_q) begin
            result_d        = sum_s[WIDTH-1:0];
            flags_d[FLAG_C] = sum_s[WIDTH];
            flags_d[FLAG_Z] = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flags_d[FLAG_N] = sum_s[WIDTH-1];
            flags_d[FLAG_V] = (lhs_val_s[WIDTH-1] == logic_s[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != lhs_val_s[WIDTH-1]);
        end else begin
            result_d = result_q;
            flags_d  = flags_q;
        end
    end

    // Result/flag stage registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            result_q <= {WIDTH{1'b0}};
            flags_q  <= RESET_FLAGS;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign ResultOut   = result_q;
    assign ResultValid = valid_q;
    assign ResultBusOE = valid_q;
    assign FlagC       = flags_q[FLAG_C];
    assign FlagZ       = flags_q[FLAG_Z];
    assign FlagN       = flags_q[FLAG_N];
    assign FlagV       = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: fixed vector table, hand sequences for carry
// forwarding, gating and reset mid-op, then random traffic against a model.
module tb_alu_exec_unit;

    localparam logic [3:0] RST_FL = 4'b0101;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       AluClock, AluActive;
    logic [7:0] ac;
    logic [7:0] LhsIn, RhsIn;
    logic [7:0] ResultOut;
    logic       ResultValid, ResultBusOE;
    logic       FlagC, FlagZ, FlagN, FlagV;

    alu_exec_unit #(.WIDTH(8), .RESET_FLAGS(RST_FL)) dut (
        .Clock(Clock), .nReset(nReset), .AluClock(AluClock), .AluActive(AluActive),
        .AC0_RHS0(ac[0]), .AC1_RHS1(ac[1]), .AC2_RHS2(ac[2]), .AC3_RHS3(ac[3]),
        .AC4_LHS0(ac[4]), .AC5_LHS1(ac[5]), .AC6_CS0(ac[6]), .AC7_CS1(ac[7]),
        .LhsIn(LhsIn), .RhsIn(RhsIn), .ResultOut(ResultOut),
        .ResultValid(ResultValid), .ResultBusOE(ResultBusOE),
        .FlagC(FlagC), .FlagZ(FlagZ), .FlagN(FlagN), .FlagV(FlagV)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       v;
        logic [7:0] r;
        logic [3:0] f;
    } pent_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ac;
        logic [7:0] res;
        logic [3:0] fl;
    } vec_t;

    pent_t      pipe[$];
    logic [7:0] m_res;
    logic [3:0] m_fl;
    logic [3:0] s_fl;
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [3:0] dut_flags();
        return {FlagV, FlagN, FlagZ, FlagC};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: signed overflow judged on true signed sums
    function automatic pent_t model_op(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic cf);
        pent_t e;
        int lg, lv, cin, s, sl, sg, ss;
        lg = 0;
        for (int i = 0; i < 8; i++) begin
            if (c[{a[i], b[i]}]) lg += (1 << i);
        end
        case (c[5:4])
            2'd1:    lv = 0;
            2'd2:    lv = 255;
            default: lv = int'(a);
        endcase
        case (c[7:6])
            2'd1:    cin = 1;
            2'd2:    cin = int'(cf);
            default: cin = 0;
        endcase
        s  = lv + lg + cin;
        sl = (lv > 127) ? lv - 256 : lv;
        sg = (lg > 127) ? lg - 256 : lg;
        ss = sl + sg + cin;
        e.v    = 1'b1;
        e.r    = 8'(s % 256);
        e.f[0] = (s > 255);
        e.f[1] = ((s % 256) == 0);
        e.f[2] = ((s % 256) >= 128);
        e.f[3] = (ss > 127) || (ss < -128);
        return e;
    endfunction

    task automatic cycle(input logic act, input logic stb, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        pent_t e, n;
        @(posedge Clock);
        #1;
        e = pipe.pop_front();
        if (e.v) begin
            m_res = e.r;
            m_fl  = e.f;
        end
        chk("valid", {7'd0, ResultValid}, {7'd0, e.v});
        chk("busoe", {7'd0, ResultBusOE}, {7'd0, e.v});
        chk("result", ResultOut, m_res);
        chk("flags", {4'd0, dut_flags()}, {4'd0, m_fl});
        AluActive = act;
        AluClock  = stb;
        LhsIn     = a;
        RhsIn     = b;
        ac        = c;
        n = '{v: 1'b0, r: 8'h00, f: 4'h0};
        if (act && stb) begin
            n    = model_op(a, b, c, s_fl[0]);
            s_fl = n.f;
        end
        pipe.push_back(n);
    endtask

    task automatic do_reset();
        nReset    = 1'b0;
        AluActive = 1'b0;
        AluClock  = 1'b0;
        pipe.delete();
        pipe.push_back('{v: 1'b0, r: 8'h00, f: 4'h0});
        pipe.push_back('{v: 1'b0, r: 8'h00, f: 4'h0});
        m_res = 8'h00;
        m_fl  = RST_FL;
        s_fl  = RST_FL;
        @(posedge Clock);
        #1;
        chk("rst_valid", {7'd0, ResultValid}, 8'h00);
        chk("rst_busoe", {7'd0, ResultBusOE}, 8'h00);
        chk("rst_result", ResultOut, 8'h00);
        chk("rst_flags", {4'd0, dut_flags()}, {4'd0, RST_FL});
        nReset = 1'b1;
    endtask

    vec_t       vt[7];
    logic [3:0] saved_fl;

    initial begin
        nReset = 1'b0; AluActive = 1'b0; AluClock = 1'b0;
        ac = 8'h00; LhsIn = 8'h00; RhsIn = 8'h00;

        // ac = {CS[1:0], LHS[1:0], RHS[3:0]}; fl = {V,N,Z,C}
        vt[0] = '{a: 8'h7F, b: 8'h01, ac: 8'h0A, res: 8'h80, fl: 4'b1100};
        vt[1] = '{a: 8'h05, b: 8'h05, ac: 8'h45, res: 8'h00, fl: 4'b0011};
        vt[2] = '{a: 8'hF0, b: 8'h3C, ac: 8'h18, res: 8'h30, fl: 4'b0000};
        vt[3] = '{a: 8'h0F, b: 8'hF0, ac: 8'h1E, res: 8'hFF, fl: 4'b0100};
        vt[4] = '{a: 8'hAA, b: 8'hFF, ac: 8'h56, res: 8'h56, fl: 4'b0000};
        vt[5] = '{a: 8'h00, b: 8'h01, ac: 8'h2A, res: 8'h00, fl: 4'b0011};
        vt[6] = '{a: 8'h80, b: 8'h80, ac: 8'hFA, res: 8'h00, fl: 4'b1011};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].ac);
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            chk("tbl_valid", {7'd0, ResultValid}, 8'h01);
            chk("tbl_result", ResultOut, vt[i].res);
            chk("tbl_flags", {4'd0, dut_flags()}, {4'd0, vt[i].fl});
        end

        // Carry forwarded between back-to-back ops
        cycle(1'b1, 1'b1, 8'hFF, 8'h01, 8'h0A);
        cycle(1'b1, 1'b1, 8'h00, 8'h00, 8'h8A);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("fwd1_valid", {7'd0, ResultValid}, 8'h01);
        chk("fwd1_result", ResultOut, 8'h00);
        chk("fwd1_c", {7'd0, FlagC}, 8'h01);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("fwd2_valid", {7'd0, ResultValid}, 8'h01);
        chk("fwd2_result", ResultOut, 8'h01);
        chk("fwd2_c", {7'd0, FlagC}, 8'h00);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("fwd_idle_valid", {7'd0, ResultValid}, 8'h00);

        // Gating: only AluActive & AluClock issues
        saved_fl = dut_flags();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("gate_flags", {4'd0, dut_flags()}, {4'd0, saved_fl});
        chk("gate_valid", {7'd0, ResultValid}, 8'h00);
        chk("gate_result", ResultOut, 8'h01);

        // Reset while an op sits in the issue stage
        cycle(1'b1, 1'b1, 8'h7F, 8'h01, 8'h0A);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("midrst_result", ResultOut, 8'h00);
        chk("midrst_flags", {4'd0, dut_flags()}, {4'd0, RST_FL});

        // Random traffic including back-to-back flag-carry ops
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
